mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants allowed while a fetch request waits.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port if_req  in  1  fetch request, held high until if_ack.
REQ-007 SHALL have port if_addr  in  AW  fetch address, stable while if_req high.
REQ-008 SHALL have port if_flush  in  1  discard the outstanding fetch result.
REQ-009 SHALL have port if_rdata  out  DW  fetched word, valid with if_ack.
REQ-010 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-011 SHALL have port d_req  in  1  data request, held high until d_ack.
REQ-012 SHALL have ports d_wr  in  1 (1=store), d_addr  in  AW, d_wdata  in  DW, d_mask  in  3, all stable while d_req high.
REQ-013 SHALL have ports d_rdata  out  DW (load data, valid with d_ack) and d_ack  out  1 (one-cycle pulse).
REQ-014 SHALL have ports mem_req  out  1, mem_wr  out  1, mem_addr  out  AW, mem_wdata  out  DW, mem_mask  out  3: the single shared memory port.
REQ-015 SHALL have ports mem_rdata  in  DW and mem_ready  in  1: memory completion, variable latency >=0 wait cycles.
REQ-016 SHALL have ports stall_if  out  1 and stall_d  out  1: pipeline stall requests.
REQ-017 SHALL have port owner_d  out  1: 1 while the data side owns the bus.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D, DONE.
REQ-019 In IDLE with no request, SHALL stay in IDLE with mem_req=0.
REQ-020 In IDLE with d_req=1, SHALL go to BUSY_D, unless if_req=1 and starve_cnt==STARVE_MAX, in which case it SHALL go to BUSY_IF.
REQ-021 In IDLE with only if_req=1, SHALL go to BUSY_IF.
REQ-022 On entering BUSY_x, SHALL register the selected requester's address, wdata, mask and wr into the mem_* outputs (mem_wr=0 and mem_mask=3'b010 for fetch), and hold them constant until the state is left.
REQ-023 mem_req SHALL be 1 exactly in states BUSY_IF and BUSY_D.
REQ-024 In BUSY_x, a rising edge with mem_ready=1 SHALL capture mem_rdata into x_rdata, assert x_ack for the single DONE cycle, and move to DONE; mem_ready=0 SHALL hold BUSY_x.
REQ-025 DONE SHALL last exactly one cycle, grant nothing, and return to IDLE, so that a request still high during its ack cycle is not re-granted.
REQ-026 Minimum transaction latency SHALL be 2 cycles from the first IDLE edge sampling req to the x_ack cycle (zero wait states); each wait cycle adds one.
REQ-027 d_rdata SHALL be updated only on load completion; on store completion it SHALL hold its previous value.
REQ-028 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on each BUSY_D grant made while if_req=1, saturate at STARVE_MAX, and clear on any BUSY_IF grant.
REQ-029 stall_if SHALL be if_req & ~if_ack, and stall_d SHALL be d_req & ~d_ack, both combinational.
REQ-030 owner_d SHALL be 1 in BUSY_D and in DONE following BUSY_D, and 0 otherwise.
REQ-031 if_flush=1 in BUSY_IF, or in the same cycle as the mem_ready completion edge, SHALL set a drop flag; the bus transaction SHALL complete normally, if_ack SHALL stay 0 in DONE, and if_rdata SHALL not update.
REQ-032 if_flush=1 in IDLE or DONE SHALL have no effect; the drop flag SHALL clear on return to IDLE.
REQ-033 Simultaneous d_req and if_req SHALL follow REQ-020; the loser stays pending and is arbitrated on the next IDLE.

Reset
REQ-034 rst=1 SHALL asynchronously force state IDLE, mem_req=0, if_ack=0, d_ack=0, owner_d=0, starve_cnt=0, drop flag=0, and all mem_*, if_rdata and d_rdata registers to 0.
REQ-035 A reset during BUSY_x SHALL abandon the transaction without producing an ack; after rst falls, operation SHALL start from IDLE.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x10, mem_ready=1 always -> mem_req high 1 cycle with mem_addr=0x10; if_ack pulse 2 cycles after req is sampled; if_rdata=mem_rdata; stall_if=1 until ack.
REQ-037 Both request in the same cycle, starve_cnt=0 -> data served first (owner_d=1); fetch granted in the IDLE following DONE.
REQ-038 d_req held continuously with if_req=1, STARVE_MAX=4 -> exactly 4 data grants, then one fetch grant, and starve_cnt returns to 0.
REQ-039 Store to 0x100 with mem_ready delayed 3 cycles -> mem_* fields held constant through 4 BUSY_D cycles; d_ack single pulse; d_rdata unchanged.
REQ-040 if_flush pulsed mid BUSY_IF -> mem transaction completes; no if_ack; if_rdata unchanged; the next fetch is acked normally.
REQ-041 rst asserted in BUSY_D -> mem_req=0 immediately, no d_ack; after release, the still-pending d_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data client and shared memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_mask;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_mask;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          stall_if;
    logic          stall_d;
    logic          owner_d;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_ack,
        input  d_req, d_wr, d_addr, d_wdata, d_mask,
        output d_rdata, d_ack,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata, mem_ready,
        output stall_if, stall_d, owner_d
    );

    // Pipeline clients and memory side.
    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_ack,
        output d_req, d_wr, d_addr, d_wdata, d_mask,
        input  d_rdata, d_ack,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_mask,
        output mem_rdata, mem_ready,
        input  stall_if, stall_d, owner_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (fetch/data) arbiter onto one shared memory port
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          drop_q, drop_d;
    logic          last_d_q, last_d_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]    mem_mask_q, mem_mask_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            last_d_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            last_d_q    <= last_d_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        last_d_d    = last_d_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // Data wins unless the fetch side has already waited out STARVE_MAX data grants.
                if (bus.if_req && (!bus.d_req || starve_q == STARVE_LIM)) begin
                    state_d     = BUSY_IF;
                    starve_d    = '0;
                    last_d_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_mask_d  = 3'b010;
                end else if (bus.d_req) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_wr_d    = bus.d_wr;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_mask_d  = bus.d_mask;
                    if (bus.if_req && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            BUSY_IF: begin
                if (bus.if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d = DONE;
                    if (!(bus.if_flush || drop_q)) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                    d_ack_d = 1'b1;
                    if (!mem_wr_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_D);
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.owner_d   = (state_q == BUSY_D) || (state_q == DONE && last_d_q);
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_d   = bus.d_req & ~d_ack_q;
endmodule
